// File: rtl/multi_timer_pkg.sv
// multi_timer_pkg: register map, channel offsets, CFG bit indices and byte-mask helper.
package multi_timer_pkg;
  localparam logic [7:0] IRQ_STATUS = 8'h00;
  localparam logic [7:0] IRQ_ENABLE = 8'h01;
  localparam logic [7:0] INFO       = 8'h02;
  localparam logic [7:0] CH_BASE    = 8'h04;
  localparam logic [7:0] CH_STRIDE  = 8'h04;
  localparam logic [1:0] CFG   = 2'd0;
  localparam logic [1:0] PRESC = 2'd1;
  localparam logic [1:0] CNT   = 2'd2;
  localparam logic [1:0] CMP   = 2'd3;
  localparam int EN      = 0;
  localparam int ONESHOT = 1;
  localparam int PWM_INV = 2;
  function automatic logic [31:0] byte_mask(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction
endpackage

// File: rtl/multi_timer_ch.sv
// multi_timer_ch: one timer channel (prescaler, counter, compare, CFG); PWM output when MULTI_TIMER_PWM_EN is defined.
module multi_timer_ch #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       wr,
  input  logic [31:0]      di,
  input  logic [31:0]      wmask,
  output logic [2:0]       cfg,
  output logic [WIDTH-1:0] presc,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] cmp,
  output logic             match
`ifdef MULTI_TIMER_PWM_EN
  ,
  output logic             pwm
`endif
);
  import multi_timer_pkg::*;
`ifdef MULTI_TIMER_PWM_EN
  localparam logic [2:0] CFG_MASK = 3'b111;
`else
  localparam logic [2:0] CFG_MASK = 3'b011;
`endif
  logic [WIDTH-1:0] pcnt, m, d;
  logic tick;
  assign m = wmask[WIDTH-1:0];
  assign d = di[WIDTH-1:0];
  assign tick = cfg[EN] && pcnt == presc;
  assign match = tick && cnt == cmp;
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg   <= '0;
      presc <= '0;
      pcnt  <= '0;
      cnt   <= '0;
      cmp   <= '0;
    end else begin
      pcnt <= (!cfg[EN] || wr[PRESC] || tick) ? '0 : pcnt + 1'b1;
      if (wr[CFG]) cfg <= ((cfg & ~wmask[2:0]) | (di[2:0] & wmask[2:0])) & CFG_MASK;
      else if (match && cfg[ONESHOT]) cfg[EN] <= 1'b0;
      if (wr[PRESC]) presc <= (presc & ~m) | (d & m);
      // a bus write to CNT takes priority over the tick update
      if (wr[CNT]) cnt <= (cnt & ~m) | (d & m);
      else if (tick) cnt <= match ? '0 : cnt + 1'b1;
      if (wr[CMP]) cmp <= (cmp & ~m) | (d & m);
    end
  end
`ifdef MULTI_TIMER_PWM_EN
  always_ff @(posedge clk) begin
    if (reset) pwm <= 1'b0;
    else pwm <= (cfg[EN] && cnt < cmp) ^ cfg[PWM_INV];
  end
`endif
endmodule

// File: rtl/multi_timer.sv
// multi_timer: NUM_CH-channel timer on the PicoSoC register bus; define MULTI_TIMER_PWM_EN for pwm_o outputs.
module multi_timer #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  reg_we,
  input  logic [3:0]  reg_re,
  input  logic [7:0]  reg_addr,
  input  logic [31:0] reg_di,
  output logic [31:0] reg_do,
  output logic        ready,
  output logic        irq
`ifdef MULTI_TIMER_PWM_EN
  ,
  output logic [NUM_CH-1:0] pwm_o
`endif
);
  import multi_timer_pkg::*;
  logic req, wr, ch_hit;
  logic [31:0] wmask, rdata;
  logic [7:0] ch_off;
  logic [3:0] ch_idx;
  logic [NUM_CH-1:0] irq_status, irq_enable, match, clr;
  logic [31:0] ch_rd [16];
  assign req = (|reg_we) || (|reg_re);
  assign wr = (|reg_we) && !ready;
  assign wmask = byte_mask(reg_we);
  assign ch_off = reg_addr - CH_BASE;
  assign ch_idx = ch_off[5:2];
  assign ch_hit = reg_addr >= CH_BASE && ch_off < 8'(NUM_CH) * CH_STRIDE;
  assign clr = (wr && reg_addr == IRQ_STATUS) ? reg_di[NUM_CH-1:0] & wmask[NUM_CH-1:0] : '0;
  for (genvar n = 0; n < 16; n++) begin : g_ch
    if (n < NUM_CH) begin : g_on
      logic [2:0] cfg;
      logic [WIDTH-1:0] presc, cnt, cmp;
      logic [3:0] wr_ch;
      assign wr_ch = (wr && ch_hit && ch_idx == 4'(n)) ? 4'b1 << ch_off[1:0] : 4'b0;
      multi_timer_ch #(.WIDTH(WIDTH)) u_ch (
        .clk   (clk),
        .reset (reset),
        .wr    (wr_ch),
        .di    (reg_di),
        .wmask (wmask),
        .cfg   (cfg),
        .presc (presc),
        .cnt   (cnt),
        .cmp   (cmp),
        .match (match[n])
`ifdef MULTI_TIMER_PWM_EN
        ,
        .pwm   (pwm_o[n])
`endif
      );
      assign ch_rd[n] = ch_off[1:0] == CFG ? 32'(cfg) : ch_off[1:0] == PRESC ? 32'(presc) :
                        ch_off[1:0] == CNT ? 32'(cnt) : 32'(cmp);
    end else begin : g_off
      assign ch_rd[n] = '0;
    end
  end
  assign rdata = reg_addr == IRQ_STATUS ? 32'(irq_status) :
                 reg_addr == IRQ_ENABLE ? 32'(irq_enable) :
                 reg_addr == INFO ? {16'h0, 8'(WIDTH), 8'(NUM_CH)} :
                 ch_hit ? ch_rd[ch_idx] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      ready      <= 1'b0;
      reg_do     <= '0;
      irq        <= 1'b0;
      irq_status <= '0;
      irq_enable <= '0;
    end else begin
      ready  <= req && !ready;
      reg_do <= (req && !ready) ? rdata : '0;
      irq    <= |(irq_status & irq_enable);
      // hardware match set wins over a simultaneous write-1-to-clear
      irq_status <= (irq_status & ~clr) | match;
      if (wr && reg_addr == IRQ_ENABLE)
        irq_enable <= (irq_enable & ~wmask[NUM_CH-1:0]) | (reg_di[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
    end
  end
endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
- Multi-channel, parametrised timer/counter peripheral on the PicoSoC simple register bus (reg_we/reg_re/reg_addr/reg_di/reg_do/ready).
- NUM_CH independent channels. Each channel has a prescaler, a WIDTH-bit up-counter, a compare register, and auto-reload or one-shot mode.
- Per-channel interrupt flags combine into one maskable irq line.
- Fully synchronous: the counter clock is a prescaler enable tick, never a derived clock.

Parameters:
- NUM_CH, 4, number of channels (1..16)
- WIDTH, 32, counter/compare/prescaler width (8..32)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- reg_we  in  4  byte write strobes; any bit set = write request
- reg_re  in  4  read strobes; any bit set = read request
- reg_addr  in  8  word address
- reg_di  in  32  write data
- reg_do  out  32  read data, valid while ready=1
- ready  out  1  one-cycle access acknowledge
- irq  out  1  OR of (IRQ_STATUS & IRQ_ENABLE), registered
- pwm_o  out  NUM_CH  only when MULTI_TIMER_PWM_EN is defined

Behaviour:
- Reset: one clk cycle with reset=1.
  - Outputs: ready=0, reg_do=0, irq=0, pwm_o=0.
  - Registers: all CFG/PRESC/CNT/CMP/IRQ_* cleared; prescaler counters cleared.
- Address map, word addresses:
  - 0x00 IRQ_STATUS: bit n = channel n match flag; write-1-to-clear.
  - 0x01 IRQ_ENABLE: read/write.
  - 0x02 INFO: read-only, {16'h0, WIDTH[7:0], NUM_CH[7:0]}.
  - Channel n at 0x04+4n: +0 CFG (bit0 EN, bit1 ONESHOT, bit2 PWM_INV), +1 PRESC, +2 CNT, +3 CMP.
  - Unmapped addresses: reads return 0, writes are ignored; ready is still asserted.
- Handshake:
  - req = (reg_we!=0)|(reg_re!=0). Master holds the request until ready.
  - ready is registered: ready <= req & ~ready. Fixed latency of 1 cycle, one-cycle pulse; no back-to-back double acknowledge.
  - Register writes commit on the same edge that asserts ready. Only bytes with reg_we[i]=1 are updated. Bits above WIDTH are ignored on write and read as 0.
  - reg_do is registered with ready and is 0 whenever ready=0.
  - If reg_we and reg_re are both nonzero, the access is a write; reg_do returns the pre-write value.
- Per-channel prescaler:
  - pcnt counts 0..PRESC; tick=1 in the cycle where pcnt==PRESC, then pcnt goes to 0.
  - PRESC=0 gives a tick every cycle.
  - pcnt runs only while EN=1, and clears on EN=0 or on any write to PRESC.
- Counter, on a tick with EN=1:
  - If CNT==CMP: CNT<=0 and IRQ_STATUS[n]<=1; if ONESHOT=1, EN clears to 0.
  - Otherwise CNT<=CNT+1, wrapping modulo 2^WIDTH. A CMP below CNT therefore matches only after wrap.
- Priority and boundary conditions:
  - A bus write to CNT overrides the tick update in the same cycle.
  - Hardware set of IRQ_STATUS wins over a W1C in the same cycle.
  - A write to CFG with EN 0->1 starts counting from the current CNT; it does not reset CNT.
  - irq is updated one cycle after a status or enable change.
- Reset mid-access: ready drops, the pending write is discarded, and the master must reissue.

Optional Feature:
- MULTI_TIMER_PWM_EN defined:
  - pwm_o[n] = EN & (CNT < CMP), registered, XOR PWM_INV.
  - CFG bit2 is writable.
- Undefined:
  - No pwm_o port.
  - CFG bit2 reads 0 and writes to it are ignored.

Decomposition:
- Package multi_timer_pkg:
  - Address constants: IRQ_STATUS, IRQ_ENABLE, INFO, CH_BASE, CH_STRIDE.
  - Channel offsets: CFG, PRESC, CNT, CMP.
  - CFG bit indices: EN, ONESHOT, PWM_INV.
- Sub-module multi_timer_ch (WIDTH):
  - Holds one channel's prescaler, counter, CMP, CFG and match pulse.
  - Instantiated NUM_CH times by a generate loop.
  - Top level owns bus decode, the readback mux, IRQ registers and ready.

Test Plan:
- Reset then read INFO (addr 0x02) with NUM_CH=4, WIDTH=32 -> reg_do=0x0000_2004; ready high exactly 1 cycle, 1 cycle after reg_re.
- Ch0: PRESC=0, CMP=3, CFG=EN -> CNT sequence 0,1,2,3,0; IRQ_STATUS[0]=1 on the wrap; IRQ_ENABLE=1 -> irq=1 one cycle later; write 0x1 to IRQ_STATUS -> irq returns to 0.
- Ch1: PRESC=2, CMP=1, CFG=EN|ONESHOT -> CNT increments every 3 clk; after the match CNT=0, EN reads 0 and CNT stays at 0.
- Write CNT=0xFFFF_FFFF with CMP=5 and EN on -> CNT wraps to 0, then matches at 5.
- Same-cycle W1C of IRQ_STATUS[2] and a ch2 match -> bit stays 1. Byte write reg_we=4'b0010 of 0xAB00 to CMP of ch3 (0x13) -> only bits [15:8] change.
- With MULTI_TIMER_PWM_EN defined: CMP=2, PRESC=0 -> pwm_o[0] pattern 1,1,0 repeating; with PWM_INV=1 -> 0,0,1.
